// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX path: serializer state encoding and framing constants.
package uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int UART_CLK_DIV_DEFAULT = 434;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with registered full/empty flags.
// Pointers carry one extra MSB so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic [AW:0]      wptr_nxt, rptr_nxt;
    logic             do_push, do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_nxt = wptr + {{AW{1'b0}}, do_push};
        rptr_nxt = rptr + {{AW{1'b0}}, do_pop};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wptr  <= wptr_nxt;
            rptr  <= rptr_nxt;
            empty <= (wptr_nxt == rptr_nxt);
            full  <= (wptr_nxt[AW] != rptr_nxt[AW]) &&
                     (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter (8 data bits, LSB first, 1 stop bit); writes never stall.
// Define UART_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CLK_DIV = UART_CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_fifo_data_en,
    input  logic [7:0] tx_fifo_data,
    output logic       txd,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow,
    output logic       tx_busy
);

    localparam int BW = $clog2(CLK_DIV);
    localparam int CW = $clog2(UART_DATA_BITS);

    uart_state_t         state, state_nxt;
    logic [BW-1:0]       baud_cnt, baud_nxt;
    logic [CW-1:0]       bit_cnt, bit_nxt;
    logic [7:0]          sr, sr_nxt;
    logic [7:0]          head;
    logic                pop, boundary, txd_nxt;
`ifdef UART_PARITY_EN
    logic                par_bit, par_nxt;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_fifo_data_en),
        .wdata (tx_fifo_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign boundary = (baud_cnt == BW'(CLK_DIV - 1));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + BW'(1);
        bit_nxt   = bit_cnt;
        sr_nxt    = sr;
        pop       = 1'b0;
`ifdef UART_PARITY_EN
        par_nxt   = par_bit;
`endif
        case (state)
            ST_IDLE: begin
                baud_nxt = baud_cnt;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    sr_nxt    = head;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = ST_START;
`ifdef UART_PARITY_EN
                    par_nxt   = ^head;
`endif
                end
            end
            ST_START: begin
                if (boundary) begin
                    baud_nxt  = '0;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (boundary) begin
                    baud_nxt = '0;
                    sr_nxt   = sr >> 1;
                    bit_nxt  = bit_cnt + CW'(1);
                    if (bit_cnt == CW'(UART_DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (boundary) begin
                    baud_nxt  = '0;
                    state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (boundary) begin
                    baud_nxt  = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // txd is decoded from the next state so the flop lines up with the state register.
        case (state_nxt)
            ST_START:  txd_nxt = 1'b0;
            ST_DATA:   txd_nxt = sr_nxt[0];
`ifdef UART_PARITY_EN
            ST_PARITY: txd_nxt = par_nxt;
`endif
            default:   txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            overflow <= 1'b0;
`ifdef UART_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            sr       <= sr_nxt;
            txd      <= txd_nxt;
            tx_busy  <= (state_nxt != ST_IDLE);
            if (tx_fifo_data_en && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
`ifdef UART_PARITY_EN
            par_bit  <= par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLK_DIV=4, DEPTH=4; a line monitor decodes frames.
// Honours UART_PARITY_EN the same way as the design.
module tb_uart_tx_fifo;

    localparam int DIV = 4;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_fifo_data_en = 1'b0;
    logic [7:0] tx_fifo_data = 8'h00;
    logic       txd, fifo_full, fifo_empty, overflow, tx_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] q_byte[$];
    int         q_start[$];
    logic       q_stop[$];
    logic       q_par[$];

    uart_tx_fifo #(
        .DEPTH   (4),
        .CLK_DIV (DIV)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .tx_fifo_data_en (tx_fifo_data_en),
        .tx_fifo_data    (tx_fifo_data),
        .txd             (txd),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .overflow        (overflow),
        .tx_busy         (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [7:0] d);
        @(negedge clk);
        tx_fifo_data_en = en;
        tx_fifo_data    = d;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (q_byte.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frame_wait_timeout", 32'(k >= budget), 32'd0);
    endtask

    task automatic clear_q();
        q_byte.delete();
        q_start.delete();
        q_stop.delete();
        q_par.delete();
    endtask

    // Line monitor: samples each bit one cycle into its CLK_DIV window, drops frames hit by reset.
    initial begin
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !txd) begin
                int         s;
                logic [7:0] b;
                logic       p, sp;
                bit         ab;
                s  = cyc;
                ab = 0;
                p  = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat ((i == 0) ? DIV + 1 : DIV) begin
                        @(negedge clk);
                        if (rst) ab = 1;
                    end
                    b[i] = txd;
                end
`ifdef UART_PARITY_EN
                repeat (DIV) begin
                    @(negedge clk);
                    if (rst) ab = 1;
                end
                p = txd;
`endif
                repeat (DIV) begin
                    @(negedge clk);
                    if (rst) ab = 1;
                end
                sp = txd;
                if (!ab) begin
                    q_byte.push_back(b);
                    q_start.push_back(s);
                    q_stop.push_back(sp);
                    q_par.push_back(p);
                end
            end
            prev = txd;
        end
    end

    initial begin
        logic [NBITS-1:0] pattern;
        int               busy_cnt;
        int               low_cnt;
        int               k;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0xA5: start, 1,0,1,0,0,1,0,1, [parity 0], stop
`ifdef UART_PARITY_EN
        pattern = 11'b1_0_10100101_0;
`else
        pattern = 10'b1_10100101_0;
`endif
        drive(1'b1, 8'hA5);
        drive(1'b0, 8'h00);
        check("single_txd_before_start", 32'(txd), 32'd1);
        check("single_empty_after_write", 32'(fifo_empty), 32'd0);
        check("single_busy_before_start", 32'(tx_busy), 32'd0);
        busy_cnt = 0;
        for (int i = 0; i < NBITS * DIV; i++) begin
            @(negedge clk);
            if (i == 0) check("single_empty_after_pop", 32'(fifo_empty), 32'd1);
            check($sformatf("single_txd_c%0d", i), 32'(txd), 32'(pattern[i / DIV]));
            if (tx_busy) busy_cnt++;
        end
        @(negedge clk);
        if (tx_busy) busy_cnt++;
        check("single_busy_cycles", 32'(busy_cnt), 32'(NBITS * DIV));
        check("single_txd_idle", 32'(txd), 32'd1);
        repeat (4) @(negedge clk);
        clear_q();

        // Burst of three bytes on consecutive cycles
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h02);
        drive(1'b1, 8'h03);
        drive(1'b0, 8'h00);
        wait_frames(3, 4 * FRAME);
        check("burst_count", 32'(q_byte.size()), 32'd3);
        if (q_byte.size() >= 3) begin
            check("burst_b0", 32'(q_byte[0]), 32'h01);
            check("burst_b1", 32'(q_byte[1]), 32'h02);
            check("burst_b2", 32'(q_byte[2]), 32'h03);
            check("burst_gap01", 32'(q_start[1] - q_start[0]), 32'(FRAME));
            check("burst_gap12", 32'(q_start[2] - q_start[1]), 32'(FRAME));
            check("burst_stop2", 32'(q_stop[2]), 32'd1);
        end
        repeat (4) @(negedge clk);
        clear_q();

        // Overflow: 0x10 pops at once, 0x11..0x14 fill, 0x15 drops
        drive(1'b1, 8'h10);
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h12);
        drive(1'b1, 8'h13);
        drive(1'b1, 8'h14);
        drive(1'b1, 8'h15);
        check("ovf_full_before_drop", 32'(fifo_full), 32'd1);
        check("ovf_clear_before_drop", 32'(overflow), 32'd0);
        drive(1'b0, 8'h00);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_full_after_drop", 32'(fifo_full), 32'd1);
        wait_frames(5, 6 * FRAME);
        repeat (FRAME + 4) @(negedge clk);
        check("ovf_count", 32'(q_byte.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < q_byte.size()) check($sformatf("ovf_b%0d", i), 32'(q_byte[i]), 32'(8'h10 + i));
        end
        check("ovf_sticky", 32'(overflow), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ovf_cleared_by_rst", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        clear_q();

        // Full FIFO with a write landing on the pop cycle
        drive(1'b1, 8'h20);
        drive(1'b1, 8'h21);
        drive(1'b1, 8'h22);
        drive(1'b1, 8'h23);
        drive(1'b1, 8'h24);
        drive(1'b0, 8'h00);
        check("fp_full", 32'(fifo_full), 32'd1);
        check("fp_no_ovf_fill", 32'(overflow), 32'd0);
        k = 0;
        while (tx_busy && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        check("fp_idle_timeout", 32'(k >= 2 * FRAME), 32'd0);
        tx_fifo_data_en = 1'b1;
        tx_fifo_data    = 8'h55;
        drive(1'b0, 8'h00);
        check("fp_no_ovf_pop", 32'(overflow), 32'd0);
        check("fp_still_full", 32'(fifo_full), 32'd1);
        check("fp_busy", 32'(tx_busy), 32'd1);
        wait_frames(6, 7 * FRAME);
        check("fp_count", 32'(q_byte.size()), 32'd6);
        if (q_byte.size() >= 6) begin
            check("fp_first", 32'(q_byte[0]), 32'h20);
            check("fp_fifth", 32'(q_byte[4]), 32'h24);
            check("fp_last", 32'(q_byte[5]), 32'h55);
        end
        repeat (4) @(negedge clk);
        clear_q();

        // Reset during DATA with two bytes queued
        drive(1'b1, 8'h30);
        drive(1'b1, 8'h31);
        drive(1'b1, 8'h32);
        drive(1'b0, 8'h00);
        repeat (10) @(negedge clk);
        check("rmf_busy_before", 32'(tx_busy), 32'd1);
        check("rmf_queued_before", 32'(fifo_empty), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rmf_txd", 32'(txd), 32'd1);
        check("rmf_empty", 32'(fifo_empty), 32'd1);
        check("rmf_busy", 32'(tx_busy), 32'd0);
        check("rmf_full", 32'(fifo_full), 32'd0);
        low_cnt = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (!txd) low_cnt++;
        end
        check("rmf_line_quiet", 32'(low_cnt), 32'd0);
        check("rmf_no_frames", 32'(q_byte.size()), 32'd0);
        clear_q();

`ifdef UART_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0
        drive(1'b1, 8'h07);
        drive(1'b1, 8'h03);
        drive(1'b0, 8'h00);
        wait_frames(2, 3 * FRAME);
        check("par_count", 32'(q_byte.size()), 32'd2);
        if (q_byte.size() >= 2) begin
            check("par_b0", 32'(q_byte[0]), 32'h07);
            check("par_p0", 32'(q_par[0]), 32'd1);
            check("par_b1", 32'(q_byte[1]), 32'h03);
            check("par_p1", 32'(q_par[1]), 32'd0);
            check("par_gap", 32'(q_start[1] - q_start[0]), 32'd45);
            check("par_stop", 32'(q_stop[1]), 32'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-stream sink for the I2C sensor application: buffers the bytes produced by the accelerometer device controller on its `tx_fifo_data_en`/`tx_fifo_data` strobe and serializes them onto an asynchronous UART TX line (8 data bits, LSB first, 1 stop bit) for a host PC. It sits directly downstream of the device controller, beside the I2C master interface, in the application top level. A write never stalls the producer. Bytes that arrive when the buffer is full are dropped and flagged.

## Interface
- `DEPTH`, 16: FIFO depth in bytes; must be a power of two, ≥2.
- `CLK_DIV`, 434: clk cycles per UART bit (≥2); 434 gives 115200 baud at 50 MHz.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_fifo_data_en`  in  1  one-cycle write strobe from the device controller.
- `tx_fifo_data`  in  8  byte to enqueue; sampled when `tx_fifo_data_en`=1.
- `txd`  out  1  UART serial output; idle high.
- `fifo_full`  out  1  occupancy == `DEPTH`.
- `fifo_empty`  out  1  occupancy == 0.
- `overflow`  out  1  sticky: a byte was dropped; cleared only by `rst`.
- `tx_busy`  out  1  serializer is not in IDLE.

## Operation
- FIFO:
  - Circular buffer with `DEPTH` entries.
  - Read/write pointers of log2(`DEPTH`)+1 bits; the extra MSB distinguishes full from empty.
  - Pointers wrap modulo 2·`DEPTH`.
- Write: when `tx_fifo_data_en`=1, the byte is stored if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is discarded and `overflow` is set.
- Pop: issued only by the serializer, in the IDLE→START transition.
- Simultaneous write and pop:
  - Both take effect and occupancy is unchanged.
  - This holds when the FIFO is full.
  - When the FIFO is empty there is no pop, because the pop requires the FIFO to be non-empty.
- Serializer FSM states: IDLE, START, DATA, STOP (PARITY when `UART_PARITY_EN` is defined).
  - IDLE: `txd`=1. If the FIFO is non-empty, pop the head byte into shift register `sr`, clear the bit counter and baud counter, and go to START.
  - START: `txd`=0 for `CLK_DIV` cycles, then go to DATA.
  - DATA: `txd`=`sr[0]`. Every `CLK_DIV` cycles, shift `sr` right and increment `bit_cnt`. After the 8th bit, go to STOP (or PARITY).
  - STOP: `txd`=1 for `CLK_DIV` cycles, then go to IDLE.
- Baud counter: counts 0..`CLK_DIV`-1; a bit boundary is the cycle where the count equals `CLK_DIV`-1.
- Back-to-back bytes: IDLE lasts exactly one cycle between the end of STOP and the next START. A frame period is therefore 10·`CLK_DIV`+1 cycles.
- Reset values:
  - `txd`=1, `fifo_empty`=1, `fifo_full`=0, `overflow`=0, `tx_busy`=0.
  - Pointers are 0 and the FSM is in IDLE.
- Reset mid-frame: the frame is abandoned, `txd` returns high on the next cycle, and the FIFO contents are discarded.

## Timing
- All outputs are registered. `txd` is driven from a flop.
- Write at edge N: the byte is in the FIFO and `fifo_empty` falls after edge N.
- FSM in IDLE at edge N+1: pop at N+1, START begins, `txd` falls after edge N+1.
  - So a byte written into an empty FIFO with an idle serializer starts its start bit one cycle after the write.
- `fifo_full`/`fifo_empty` update in the same cycle as the pointer change.
- `overflow` rises the cycle after the dropped write.
- `tx_busy` is high from START through STOP, inclusive.

## Configuration
- `UART_PARITY_EN`:
  - Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for `CLK_DIV` cycles. Frame = 11·`CLK_DIV`+1 cycles.
  - Undefined: no parity state or logic, 8N1 framing.

## Structure
- The shared package `uart_pkg` holds:
  - the FSM state encoding (`ST_IDLE`, `ST_START`, `ST_DATA`, `ST_PARITY`, `ST_STOP`);
  - `UART_DATA_BITS`=8;
  - the default `CLK_DIV` constant.
- One sub-module, `sync_fifo`: a parameterized width/depth single-clock FIFO with push/pop/full/empty.
  - It is instantiated with width 8.
  - The serializer FSM lives in the top of `uart_tx_fifo`.

## Test plan
Benches use `CLK_DIV`=4 and `DEPTH`=4.
- Single byte: write 0xA5 with the FIFO idle → `txd` falls one cycle later, then for 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1. `tx_busy` is high for 40 cycles.
- Burst: write 0x01, 0x02, 0x03 on consecutive cycles → three frames in order, start bits spaced exactly 41 cycles apart.
- Overflow: six consecutive writes 0x10..0x15 while idle → 0x10 is popped at once and 0x11..0x14 fill the FIFO. 0x15 is dropped, `overflow`=1, and exactly five frames are sent.
- Full with simultaneous pop: fill the FIFO, then write 0x55 on the IDLE→START pop cycle → accepted, no overflow, 0x55 is sent last.
- Reset mid-frame: assert `rst` during DATA with 2 bytes queued → next cycle `txd`=1, `fifo_empty`=1, `tx_busy`=0, and no further frames.
- With `UART_PARITY_EN`: 0x07 → parity bit 1; 0x03 → parity bit 0. Frame spacing is 45 cycles.
